// File: rtl/change_event_logger.sv
// Change-event logger: timestamps value changes of a sampled 1-bit output and queues them for draining.
// Define LOGGER_CHECK_EN to add the EXPECTED truth-table checker (mismatch / err_count ports).
module change_event_logger #(
    parameter int                  CTX_W    = 4,
    parameter int                  TIME_W   = 16,
    parameter int                  DEPTH    = 8,
    parameter logic [2**CTX_W-1:0] EXPECTED = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     obs,
    input  logic [CTX_W-1:0]         ctx,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TIME_W-1:0]        ev_time,
    output logic                     ev_value,
    output logic [CTX_W-1:0]         ev_ctx,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
`ifdef LOGGER_CHECK_EN
    ,
    output logic                     mismatch,
    output logic [7:0]               err_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = TIME_W + 1 + CTX_W;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [TIME_W-1:0] time_reg;
    logic              prev_reg;
    logic              armed_reg;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  count_reg;
    logic [LVL_W-1:0]  count_next;
    logic [REC_W-1:0]  head_reg;
    logic              overflow_reg;
    logic [7:0]        drop_reg;

    logic              event_hit;
    logic              pop;
    logic              push;
    logic              drop;
    logic              full;
    logic              load_new;
    logic [REC_W-1:0]  rec;
    logic [PTR_W-1:0]  rd_ptr_inc;

    always_comb begin
        event_hit  = en && (armed_reg || (obs != prev_reg));
        rec        = {time_reg, obs, ctx};
        full       = (count_reg == FULL_LVL);
        pop        = (count_reg != '0) && ev_ready;
        push       = event_hit && (!full || pop);
        drop       = event_hit && full && !pop;
        rd_ptr_inc = rd_ptr_reg + 1'b1;
        // The head register takes the incoming record only when nothing older survives this edge.
        load_new   = push && ((count_reg == '0) || ((count_reg == LVL_W'(1)) && pop));
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_reg     <= '0;
            prev_reg     <= 1'b0;
            armed_reg    <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
            drop_reg     <= '0;
        end else begin
            time_reg  <= time_reg + 1'b1;
            count_reg <= count_next;
            if (en) begin
                prev_reg  <= obs;
                armed_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            if (load_new) begin
                head_reg <= rec;
            end else if (pop && (count_reg > LVL_W'(1))) begin
                head_reg <= mem[rd_ptr_inc];
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_reg != 8'hFF) begin
                    drop_reg <= drop_reg + 1'b1;
                end
            end
        end
    end

    assign ev_valid                    = (count_reg != '0);
    assign {ev_time, ev_value, ev_ctx} = head_reg;
    assign level                       = count_reg;
    assign overflow                    = overflow_reg;
    assign drop_count                  = drop_reg;

`ifdef LOGGER_CHECK_EN
    logic       mismatch_reg;
    logic [7:0] err_reg;
    logic       disagree;

    assign disagree = en && (obs != EXPECTED[ctx]);

    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_reg <= 1'b0;
            err_reg      <= '0;
        end else begin
            mismatch_reg <= disagree;
            if (disagree && (err_reg != 8'hFF)) begin
                err_reg <= err_reg + 1'b1;
            end
        end
    end

    assign mismatch  = mismatch_reg;
    assign err_count = err_reg;
`endif

endmodule

// File: tb/tb_change_event_logger.sv
// Bench for change_event_logger: queue-based reference model checked every cycle on two instances
// (TIME_W=16 and TIME_W=4), plus directed literal expectations.
module tb_change_event_logger;

    localparam logic [15:0] EXP = 16'h6996;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       obs = 1'b0;
    logic [3:0] ctx = '0;
    logic       ev_ready = 1'b0;

    logic        a_ev_valid, b_ev_valid;
    logic [15:0] a_ev_time;
    logic [3:0]  b_ev_time;
    logic        a_ev_value, b_ev_value;
    logic [3:0]  a_ev_ctx, b_ev_ctx;
    logic [3:0]  a_level, b_level;
    logic        a_overflow, b_overflow;
    logic [7:0]  a_drop, b_drop;
`ifdef LOGGER_CHECK_EN
    logic        a_mismatch, b_mismatch;
    logic [7:0]  a_err, b_err;
`endif

    always #5 clk = ~clk;

    change_event_logger #(.CTX_W(4), .TIME_W(16), .DEPTH(8), .EXPECTED(EXP)) dut_a (
        .clk(clk), .reset(reset), .en(en), .obs(obs), .ctx(ctx),
        .ev_valid(a_ev_valid), .ev_ready(ev_ready), .ev_time(a_ev_time),
        .ev_value(a_ev_value), .ev_ctx(a_ev_ctx), .level(a_level),
        .overflow(a_overflow), .drop_count(a_drop)
`ifdef LOGGER_CHECK_EN
        , .mismatch(a_mismatch), .err_count(a_err)
`endif
    );

    change_event_logger #(.CTX_W(4), .TIME_W(4), .DEPTH(8), .EXPECTED(EXP)) dut_b (
        .clk(clk), .reset(reset), .en(en), .obs(obs), .ctx(ctx),
        .ev_valid(b_ev_valid), .ev_ready(ev_ready), .ev_time(b_ev_time),
        .ev_value(b_ev_value), .ev_ctx(b_ev_ctx), .level(b_level),
        .overflow(b_overflow), .drop_count(b_drop)
`ifdef LOGGER_CHECK_EN
        , .mismatch(b_mismatch), .err_count(b_err)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a plain queue of records plus the running cycle number.
    typedef struct packed {
        logic [31:0] t;
        logic        v;
        logic [3:0]  c;
    } rec_t;

    rec_t        q[$];
    rec_t        hold;
    rec_t        r;
    logic [31:0] m_time;
    logic        m_prev, m_armed, m_ovf, m_pop, m_ev, m_mm;
    int          m_drops, m_err;
    logic [3:0]  m_last_ctx;
    logic        chk_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_time  = 0;
            m_prev  = 1'b0;
            m_armed = 1'b1;
            m_ovf   = 1'b0;
            m_drops = 0;
            hold    = '0;
            m_mm    = 1'b0;
            m_err   = 0;
        end else begin
            m_pop = (q.size() != 0) && ev_ready;
            m_ev  = en && (m_armed || (obs != m_prev));
            if (m_pop) void'(q.pop_front());
            if (m_ev) begin
                if (q.size() < 8) begin
                    r.t = m_time;
                    r.v = obs;
                    r.c = ctx;
                    q.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (en) begin
                m_prev  = obs;
                m_armed = 1'b0;
            end
            m_mm = en && (obs != EXP[ctx]);
            if (m_mm && m_err < 255) m_err++;
            m_last_ctx = ctx;
            m_time++;
            if (q.size() != 0) hold = q[0];
        end
    end

    logic [31:0] la_t[$];
    logic        la_v[$];
    logic [31:0] lb_t[$];
    logic        lb_v[$];
    int          max_level;
    logic [15:0] mm_mask;

    always @(negedge clk) begin
        if (chk_on) begin
            check("a_valid", a_ev_valid, q.size() != 0);
            check("a_level", a_level, q.size());
            check("a_time", a_ev_time, hold.t[15:0]);
            check("a_value", a_ev_value, hold.v);
            check("a_ctx", a_ev_ctx, hold.c);
            check("a_overflow", a_overflow, m_ovf);
            check("a_drop", a_drop, m_drops);
            check("b_valid", b_ev_valid, q.size() != 0);
            check("b_level", b_level, q.size());
            check("b_time", b_ev_time, hold.t[3:0]);
            check("b_value", b_ev_value, hold.v);
            check("b_drop", b_drop, m_drops);
`ifdef LOGGER_CHECK_EN
            check("a_mismatch", a_mismatch, m_mm);
            check("a_err", a_err, m_err);
            check("b_err", b_err, m_err);
            if (a_mismatch) mm_mask[m_last_ctx] = 1'b1;
`endif
        end
        if (!reset) begin
            if (int'(a_level) > max_level) max_level = int'(a_level);
            if (a_ev_valid && ev_ready) begin
                la_t.push_back(32'(a_ev_time));
                la_v.push_back(a_ev_value);
            end
            if (b_ev_valid && ev_ready) begin
                lb_t.push_back(32'(b_ev_time));
                lb_v.push_back(b_ev_value);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b0; obs = 1'b0; ctx = '0; ev_ready = 1'b0;
        step(2);
        chk_on = 1'b1;
        la_t.delete(); la_v.delete(); lb_t.delete(); lb_v.delete();
        max_level = 0;
        mm_mask = '0;
        check("rst_valid", a_ev_valid, 1'b0);
        check("rst_level", a_level, 4'd0);
        reset = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // First sample after reset is always logged, one cycle late.
        do_reset();
        step(1);
        check("t1_valid_c1", a_ev_valid, 1'b1);
        step(4);
        check("t1_level", a_level, 4'd1);
        check("t1_time", a_ev_time, 16'd0);
        check("t1_value", a_ev_value, 1'b0);
        check("t1_ctx", a_ev_ctx, 4'd0);

        // Toggles at cycles 3 and 7 with a ready consumer.
        do_reset();
        ev_ready = 1'b1;
        ctx = 4'h5;
        step(3);
        obs = 1'b1;
        step(4);
        obs = 1'b0;
        step(4);
        check("t2_count", la_t.size(), 3);
        if (la_t.size() == 3) begin
            check("t2_time0", la_t[0], 0);
            check("t2_time1", la_t[1], 3);
            check("t2_time2", la_t[2], 7);
            check("t2_val1", la_v[1], 1'b1);
            check("t2_val2", la_v[2], 1'b0);
        end
        check("t2_maxlvl", max_level, 1);

        // Overflow: 11 attempted events into an 8-deep FIFO.
        do_reset();
        ctx = 4'hA;
        step(1);
        for (int i = 0; i < 10; i++) begin
            obs = ~obs;
            ctx = 4'(i);
            step(1);
        end
        check("t3_level", a_level, 4'd8);
        check("t3_overflow", a_overflow, 1'b1);
        check("t3_drop", a_drop, 8'd3);

        // Full FIFO, push and pop on the same edge, then drain.
        obs = ~obs;
        ev_ready = 1'b1;
        step(1);
        check("t4_level", a_level, 4'd8);
        check("t4_drop", a_drop, 8'd3);
        step(10);
        check("t4_count", la_t.size(), 9);
        if (la_t.size() == 9) begin
            check("t4_first", la_t[0], 0);
            check("t4_seventh", la_t[7], 7);
            check("t4_last", la_t[8], 11);
        end
        check("t4_empty", a_ev_valid, 1'b0);
        check("t4_hold", a_ev_time, 16'd11);

        // Timestamp wrap on the 4-bit instance.
        do_reset();
        step(14);
        obs = 1'b1;
        step(2);
        obs = 1'b0;
        step(1);
        check("t5_level", b_level, 4'd3);
        ev_ready = 1'b1;
        step(4);
        check("t5_count", lb_t.size(), 3);
        if (lb_t.size() == 3) begin
            check("t5_b_t1", lb_t[1], 14);
            check("t5_b_t2", lb_t[2], 0);
            check("t5_b_v1", lb_v[1], 1'b1);
        end
        if (la_t.size() == 3) begin
            check("t5_a_t2", la_t[2], 16);
        end else begin
            check("t5_a_count", la_t.size(), 3);
        end

        // Truth-table sweep, then reset in the middle of a drain.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            ctx = 4'(c);
            step(1);
        end
        step(1);
`ifdef LOGGER_CHECK_EN
        check("t6_err", a_err, 8'd8);
        check("t6_mask", mm_mask, 16'h6996);
`endif
        obs = 1'b1; step(1);
        obs = 1'b0; step(1);
        obs = 1'b1; step(1);
        check("t6_level", a_level, 4'd4);
        ev_ready = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        check("t6_rst_valid", a_ev_valid, 1'b0);
        check("t6_rst_level", a_level, 4'd0);
        check("t6_rst_drop", a_drop, 8'd0);
`ifdef LOGGER_CHECK_EN
        check("t6_rst_err", a_err, 8'd0);
`endif
        reset = 1'b0;
        step(1);
        check("t6_rearm_valid", a_ev_valid, 1'b1);
        check("t6_rearm_time", a_ev_time, 16'd0);
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
